// File: rtl/pe_pkg.sv
// Shared definitions for the PE array feeder: FSM states, read tags and the
// byte-to-fixed-point conversions used on the weight and ifmap buses.
package pe_pkg;

  localparam int BUF_DATA_WIDTH = 8;
  localparam int TOP_BITS       = 2;
  localparam int BOT_BITS       = 14;
  localparam int DATA_WIDTH     = TOP_BITS + BOT_BITS;
  localparam int WEIGHT_SHIFT   = BOT_BITS - BUF_DATA_WIDTH + 1;
  localparam int IFMAP_SHIFT    = BOT_BITS - BUF_DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WCLR,
    ST_WLOAD,
    ST_ILOAD,
    ST_DONE
  } feeder_state_t;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_WEIGHT,
    TAG_IFMAP
  } rd_tag_t;

  // Weight byte is a signed Q1.7 value aligned onto the array's fraction point.
  function automatic logic [DATA_WIDTH-1:0] to_weight_fx(input logic [BUF_DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] ext;
    ext = {{(DATA_WIDTH-BUF_DATA_WIDTH){b[BUF_DATA_WIDTH-1]}}, b};
    return ext << WEIGHT_SHIFT;
  endfunction

  // Ifmap byte is an unsigned fraction (byte/256).
  function automatic logic [DATA_WIDTH-1:0] to_ifmap_fx(input logic [BUF_DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] ext;
    ext = {{(DATA_WIDTH-BUF_DATA_WIDTH){1'b0}}, b};
    return ext << IFMAP_SHIFT;
  endfunction

endpackage

// File: rtl/pe_feeder.sv
// Streams one kernel row of weights and a full ifmap from the global buffer
// into the leftmost PE of a row, converting bytes to array fixed-point.
module pe_feeder
  import pe_pkg::*;
#(
  parameter int G_BUF_ADDR_WIDTH = 10,
  parameter int G_BUF_DATA_WIDTH = BUF_DATA_WIDTH,
  parameter int G_TOP_BITS       = TOP_BITS,
  parameter int G_BOT_BITS       = BOT_BITS,
  parameter int G_KERNEL_SIZE    = 5,
  parameter int G_IMAGE_HEIGHT   = 28,
  parameter int G_IMAGE_WIDTH    = 28
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic                                hold_i,
  input  logic [$clog2(G_KERNEL_SIZE)-1:0]    kernel_row_i,
  input  logic [G_BUF_ADDR_WIDTH-1:0]         weight_base_i,
  input  logic [G_BUF_ADDR_WIDTH-1:0]         ifmap_base_i,
  output logic                                buf_rd_en_o,
  output logic [G_BUF_ADDR_WIDTH-1:0]         buf_addr_o,
  input  logic [G_BUF_DATA_WIDTH-1:0]         buf_rd_data_i,
  output logic                                weight_clr_o,
  output logic                                weight_vld_o,
  output logic [G_TOP_BITS+G_BOT_BITS-1:0]    weight_o,
  output logic                                ifmap_vld_o,
  output logic                                ifmap_row_o,
  output logic [G_TOP_BITS+G_BOT_BITS-1:0]    ifmap_o,
  output logic                                busy_o,
  output logic                                done_o
);

  localparam int AW  = G_BUF_ADDR_WIDTH;
  localparam int DW  = G_TOP_BITS + G_BOT_BITS;
  localparam int KCW = $clog2(G_KERNEL_SIZE + 1);
  localparam int XW  = (G_IMAGE_WIDTH  > 1) ? $clog2(G_IMAGE_WIDTH)  : 1;
  localparam int YW  = (G_IMAGE_HEIGHT > 1) ? $clog2(G_IMAGE_HEIGHT) : 1;

  localparam logic [KCW-1:0] K_COUNT  = KCW'(G_KERNEL_SIZE);
  localparam logic [AW-1:0]  K_STRIDE = AW'(G_KERNEL_SIZE);
  localparam logic [XW-1:0]  X_LAST   = XW'(G_IMAGE_WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST   = YW'(G_IMAGE_HEIGHT - 1);

  feeder_state_t       state_q;
  logic [AW-1:0]       w_start_q, i_base_q, addr_q;
  logic [KCW-1:0]      k_q;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic                drain_q;
  logic                rd_en_q, row_q, row_out_q;
  rd_tag_t             kind_q, tag_q;
  logic                busy_q, done_q, clr_q;
  logic [DW-1:0]       weight_hold_q, ifmap_hold_q;
  logic                last_pixel;

  assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      w_start_q     <= '0;
      i_base_q      <= '0;
      addr_q        <= '0;
      k_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      drain_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      row_q         <= 1'b0;
      row_out_q     <= 1'b0;
      kind_q        <= TAG_NONE;
      tag_q         <= TAG_NONE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      clr_q         <= 1'b0;
      // NOTE: the held output words are reset too, so every data bus reads 0 out of reset.
      weight_hold_q <= '0;
      ifmap_hold_q  <= '0;
    end else begin
      // NOTE: non-blocking throughout so each branch below sees pre-edge register values.
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      tag_q  <= rd_en_q ? kind_q : TAG_NONE;
      if (rd_en_q && kind_q == TAG_IFMAP) row_out_q <= row_q;
      if (tag_q == TAG_WEIGHT) weight_hold_q <= to_weight_fx(buf_rd_data_i);
      if (tag_q == TAG_IFMAP)  ifmap_hold_q  <= to_ifmap_fx(buf_rd_data_i);

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q   <= ST_WCLR;
            busy_q    <= 1'b1;
            clr_q     <= 1'b1;
            w_start_q <= weight_base_i + AW'(kernel_row_i) * K_STRIDE;
            i_base_q  <= ifmap_base_i;
          end
        end
        ST_WCLR: begin
          state_q <= ST_WLOAD;
          rd_en_q <= 1'b1;
          addr_q  <= w_start_q;
          kind_q  <= TAG_WEIGHT;
          k_q     <= KCW'(1);
        end
        // k_q counts weight reads already scheduled; rd_en_q issues them a cycle later.
        ST_WLOAD: begin
          if (hold_i) begin
            rd_en_q <= 1'b0;
          end else if (k_q != K_COUNT) begin
            rd_en_q <= 1'b1;
            addr_q  <= addr_q + 1'b1;
            k_q     <= k_q + 1'b1;
          end else begin
            state_q <= ST_ILOAD;
            rd_en_q <= 1'b1;
            addr_q  <= i_base_q;
            kind_q  <= TAG_IFMAP;
            row_q   <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
          end
        end
        ST_ILOAD: begin
          if (hold_i) begin
            rd_en_q <= 1'b0;
          end else if (!last_pixel) begin
            rd_en_q <= 1'b1;
            addr_q  <= addr_q + 1'b1;
            if (x_q == X_LAST) begin
              x_q   <= '0;
              y_q   <= y_q + 1'b1;
              row_q <= y_q[0];
            end else begin
              x_q <= x_q + 1'b1;
            end
          end else if (!drain_q) begin
            rd_en_q <= 1'b0;
            drain_q <= 1'b1;
          end else begin
            drain_q <= 1'b0;
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          k_q     <= '0;
          x_q     <= '0;
          y_q     <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read data arrives the cycle after the strobe, so data outputs bypass the
  // hold register while the matching tag is live.
  assign weight_vld_o = (tag_q == TAG_WEIGHT);
  assign ifmap_vld_o  = (tag_q == TAG_IFMAP);
  assign weight_o     = weight_vld_o ? to_weight_fx(buf_rd_data_i) : weight_hold_q;
  assign ifmap_o      = ifmap_vld_o  ? to_ifmap_fx(buf_rd_data_i)  : ifmap_hold_q;
  assign ifmap_row_o  = row_out_q;
  assign buf_rd_en_o  = rd_en_q;
  assign buf_addr_o   = addr_q;
  assign weight_clr_o = clr_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
